fifo_stream_reader: RTL

- Read-side drain engine for the team's single-clock FIFO (registered RAM read port).
- Issues read strobes against the FIFO's empty flag and absorbs the 1-cycle RAM read latency in a 2-entry buffer.
- Presents data as a valid/ready stream, packetised into bursts with an end-of-burst marker.
- A partial burst is closed by an idle timeout.

---
 rtl/fifo_stream_reader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side drain engine for the single-clock FIFO.
// Issues reads against the FIFO empty flag. A 2-entry buffer absorbs the
// one-cycle RAM read latency. Buffered words leave as a valid/ready stream,
// cut into bursts of burst_len beats. A lone trailing word that waits
// longer than the idle timeout closes its burst.
module fifo_stream_reader #(
    parameter int dw      = 8,
    parameter int bw      = 8,
    parameter int tw      = 4,
    parameter int timeout = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          enable,
    input  logic [bw-1:0] burst_len,
    input  logic [dw-1:0] fifo_dout,
    input  logic          fifo_empty,
    output logic          fifo_re,
    output logic [dw-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          busy
);

    localparam logic [tw-1:0] timeout_v = tw'(timeout);

    // Registered state. buf0 is the head of the buffer and buf1 the tail.
    logic [1:0]    occ;
    logic          pend;
    logic [dw-1:0] buf0, buf1;
    logic [bw-1:0] beat;
    logic [bw-1:0] eff_len;
    logic [tw-1:0] idle;

    // Next-state values.
    logic          pop;
    logic [2:0]    fill;
    logic [1:0]    occ_pop;
    logic [2:0]    occ_n;
    logic [dw-1:0] buf0_n, buf1_n;
    logic [bw-1:0] beat_n, eff_len_n, len_in, len_cur;
    logic [tw-1:0] idle_n;
    logic          hold, succ, is_final, timed, rel;
    logic          valid_n, last_n;
    logic [dw-1:0] data_n;

    // Issue a read only when the buffer has room once this cycle's pop and
    // the read already in flight are taken into account.
    always_comb begin
        pop     = m_valid & m_ready;
        fill    = {1'b0, occ} + {2'b0, pend} - {2'b0, pop};
        fifo_re = enable & ~fifo_empty & (fill < 3'd2) & rst & ~clr;
    end

    // Compute the post-edge buffer contents, the release decision and the
    // burst bookkeeping from the state this cycle will leave behind.
    always_comb begin
        // NOTE: every always_comb output is given a default first, so no path
        // can leave it unassigned and infer a latch.
        buf0_n    = buf0;
        buf1_n    = buf1;
        occ_pop   = occ - {1'b0, pop};
        occ_n     = 3'd0;
        beat_n    = beat;
        len_in    = (burst_len == '0) ? bw'(1) : burst_len;
        len_cur   = eff_len;
        idle_n    = '0;
        hold      = 1'b0;
        succ      = 1'b0;
        is_final  = 1'b0;
        timed     = 1'b0;
        rel       = 1'b0;
        valid_n   = 1'b0;
        last_n    = 1'b0;
        data_n    = m_data;
        eff_len_n = eff_len;

        // A pop advances the tail into the head slot.
        if (pop) begin
            buf0_n = buf1;
        end
        // Read data arriving this cycle lands behind whatever survives the pop.
        if (pend) begin
            if (occ_pop == 2'd0) begin
                buf0_n = fifo_dout;
            end else begin
                buf1_n = fifo_dout;
            end
        end
        occ_n = {1'b0, occ_pop} + {2'b0, pend};

        if (pop) begin
            beat_n = m_last ? '0 : beat + bw'(1);
        end
        // The burst length is latched as the first beat of a burst is released.
        len_cur = (beat_n == '0) ? len_in : eff_len;

        // The idle timer runs only while one unreleased word sits alone.
        if (occ == 2'd1 && !pend && !m_valid) begin
            idle_n = (idle >= timeout_v) ? idle : idle + tw'(1);
        end

        hold     = m_valid & ~pop;
        succ     = (occ_n == 3'd2) | fifo_re;
        is_final = (beat_n == len_cur - bw'(1));
        timed    = (idle_n >= timeout_v);
        rel      = ~hold & (occ_n != 3'd0) & (succ | is_final | timed);

        valid_n  = hold | rel;
        if (hold) begin
            last_n = m_last;
        end else begin
            last_n = rel & (is_final | (timed & ~succ));
        end
        if (rel) begin
            data_n = buf0_n;
            if (beat_n == '0) begin
                eff_len_n = len_in;
            end
        end
    end

    // Control state: cleared by reset or flush, otherwise takes the next state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the values from before this edge.
        if (!rst || clr) begin
            occ     <= 2'd0;
            pend    <= 1'b0;
            beat    <= '0;
            eff_len <= bw'(1);
            idle    <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
        end else begin
            assert (occ_n <= 3'd2);
            occ     <= occ_n[1:0];
            pend    <= fifo_re;
            beat    <= beat_n;
            eff_len <= eff_len_n;
            idle    <= idle_n;
            m_valid <= valid_n;
            m_last  <= last_n;
            m_data  <= data_n;
        end
    end

    // Buffer storage: contents are only meaningful below occ.
    always_ff @(posedge clk) begin
        // NOTE: the data slots are deliberately left out of reset; occ alone
        // says which of them hold live words.
        buf0 <= buf0_n;
        buf1 <= buf1_n;
    end

    assign busy = (occ != 2'd0) | pend;

endmodule
